// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Optional macro ALU_ARB_DIVZ_EN: divide-by-zero bypasses the ALU and flags rsp_divz.
module alu_arbiter #(
    parameter int WIDTH         = 64,
    parameter int MULDIV_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [WIDTH-1:0] alu_input1,
    output logic [WIDTH-1:0] alu_input2,
    output logic [1:0]       alu_signal,
    input  logic [WIDTH-1:0] alu_output,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_divz
);
    // state | meaning
    // IDLE  | waiting for a request; grant decided combinationally
    // EXEC  | ALU inputs held, cnt counting down to the capture cycle
    // RESP  | result presented until the consumer accepts it
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [1:0] OP_DIV = 2'b11;

    state_t           state, state_nxt;
    logic             grant;
    logic             last_grant;
    logic [3:0]       cnt;
    logic             sel_valid;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             divz_hit;
    logic             accept;
    logic             capture;
    logic             divz_q;

    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid)
            grant = ~last_grant;
        else if (req1_valid)
            grant = 1'b1;
    end

    assign sel_valid = grant ? req1_valid : req0_valid;
    assign sel_op    = grant ? req1_op    : req0_op;
    assign sel_a     = grant ? req1_a     : req0_a;
    assign sel_b     = grant ? req1_b     : req0_b;

    // Ready is masked by rst_n so nothing looks accepted while reset is held.
    assign req0_ready = rst_n && (state == IDLE) && !grant;
    assign req1_ready = rst_n && (state == IDLE) &&  grant;

`ifdef ALU_ARB_DIVZ_EN
    assign divz_hit = (sel_op == OP_DIV) && (sel_b == '0);
`else
    assign divz_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (sel_valid) begin
                    accept    = 1'b1;
                    state_nxt = divz_hit ? RESP : EXEC;
                end
            end
            EXEC: begin
                if (cnt == 4'd1) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rsp_valid = (state == RESP);
    assign rsp_divz  = divz_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_input1 <= '0;
            alu_input2 <= '0;
            alu_signal <= 2'b00;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            divz_q     <= 1'b0;
            cnt        <= 4'd0;
            last_grant <= 1'b1;
        end else if (accept) begin
            alu_signal <= sel_op;
            alu_input1 <= sel_a;
            alu_input2 <= sel_b;
            rsp_id     <= grant;
            last_grant <= grant;
            // op[1] set means mul/div, which needs the full settle window
            cnt        <= sel_op[1] ? 4'(MULDIV_CYCLES) : 4'd1;
            if (divz_hit) begin
                rsp_data <= '1;
                divz_q   <= 1'b1;
            end
        end else if (state == EXEC) begin
            cnt <= cnt - 4'd1;
            if (capture) begin
                rsp_data <= alu_output;
                divz_q   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural ALU.
// Honours ALU_ARB_DIVZ_EN the same way the design does.
module tb_alu_arbiter;
    localparam int W = 64;
    localparam logic [1:0] OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_DIV = 2'b11;
    localparam logic [W-1:0] ONES = {W{1'b1}};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [1:0]   req0_op, req1_op;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [W-1:0] alu_input1, alu_input2, alu_output;
    logic [1:0]   alu_signal;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_divz;
    logic [W-1:0] rsp_data;

    int checks = 0;
    int passed = 0;

    alu_arbiter #(.WIDTH(W), .MULDIV_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_input1(alu_input1), .alu_input2(alu_input2), .alu_signal(alu_signal),
        .alu_output(alu_output),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_divz(rsp_divz)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (alu_signal)
            OP_ADD:  alu_output = alu_input1 + alu_input2;
            OP_SUB:  alu_output = alu_input1 - alu_input2;
            OP_MUL:  alu_output = alu_input1 * alu_input2;
            default: alu_output = (alu_input2 == '0) ? ONES : alu_input1 / alu_input2;
        endcase
    end

    // Presents a request and returns #1 after the accepting edge.
    task automatic do_req(input bit id, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int t;
        bit ok;
        if (id) begin
            req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
        end else begin
            req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
        end
        ok = 1'b0;
        for (t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        checks++;
        if (!ok) $display("FAIL accept_timeout: req%0d not accepted within 50 cycles", id);
        else passed++;
    endtask

    // Latency in cycles from the accepting edge to the first cycle rsp_valid is seen.
    task automatic wait_rsp(output int lat);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = c;
                break;
            end
            @(posedge clk);
        end
    endtask

    task automatic consume();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int lat;
        bit quiet;
        rst_n = 1'b0;
        req0_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready}); else passed++;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); else passed++;
        checks++; if (rsp_data !== '0) $display("FAIL reset_rsp_data: got %h want 0", rsp_data); else passed++;
        checks++; if ({alu_signal, alu_input1, alu_input2} !== '0) $display("FAIL reset_alu_inputs: got %b %h %h want 0", alu_signal, alu_input1, alu_input2); else passed++;
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        rst_n = 1'b1;

        do_req(1'b1, OP_MUL, 64'd6, 64'd7);
        consume();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL midexec_rsp_valid: got %b want 0", rsp_valid); else passed++;
        checks++; if (rsp_id !== 1'b0) $display("FAIL midexec_rsp_id: got %b want 0", rsp_id); else passed++;
        checks++; if ({alu_signal, alu_input1, alu_input2} !== '0) $display("FAIL midexec_alu_inputs: got %b %h %h want 0", alu_signal, alu_input1, alu_input2); else passed++;
        checks++; if (rsp_divz !== 1'b0) $display("FAIL midexec_divz: got %b want 0", rsp_divz); else passed++;
        rst_n = 1'b1;
        quiet = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid) quiet = 1'b0;
        end
        checks++; if (!quiet) $display("FAIL post_reset_no_rsp: rsp_valid seen 1 want 0"); else passed++;
        @(posedge clk);
        #1;

        do_req(1'b0, OP_ADD, 64'd5, 64'd7);
        wait_rsp(lat);
        checks++; if (lat != 2) $display("FAIL add_latency: got %0d want 2", lat); else passed++;
        checks++; if (rsp_id !== 1'b0) $display("FAIL add_id: got %b want 0", rsp_id); else passed++;
        checks++; if (rsp_data !== 64'd12) $display("FAIL add_data: got %0d want 12", rsp_data); else passed++;
        consume();
    endtask

    task automatic test_tie();
        int lat, t;
        bit g;
        bit exp_id [3];
        logic [W-1:0] exp_data [3];
        exp_id = '{1'b0, 1'b1, 1'b0};
        exp_data = '{64'd2, 64'd4, 64'd2};
        apply_reset();
        req0_op = OP_ADD; req0_a = 64'd1; req0_b = 64'd1;
        req1_op = OP_ADD; req1_a = 64'd2; req1_b = 64'd2;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            t = 0;
            @(negedge clk);
            while (!(req0_ready || req1_ready) && t < 20) begin
                @(negedge clk);
                t++;
            end
            g = req1_ready;
            checks++; if (t >= 20) $display("FAIL tie_ready_timeout[%0d]: no ready within 20 cycles", k); else passed++;
            checks++; if (g !== exp_id[k]) $display("FAIL tie_grant[%0d]: got %b want %b", k, g, exp_id[k]); else passed++;
            @(posedge clk);
            #1;
            wait_rsp(lat);
            checks++; if (rsp_id !== exp_id[k]) $display("FAIL tie_rsp_id[%0d]: got %b want %b", k, rsp_id, exp_id[k]); else passed++;
            checks++; if (rsp_data !== exp_data[k]) $display("FAIL tie_rsp_data[%0d]: got %0d want %0d", k, rsp_data, exp_data[k]); else passed++;
            consume();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_mul_latency();
        do_req(1'b1, OP_MUL, 64'd3, ONES);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            checks++; if (rsp_valid !== 1'b0) $display("FAIL mul_early_valid[T+%0d]: got %b want 0", c, rsp_valid); else passed++;
            checks++;
            if (alu_signal !== OP_MUL || alu_input1 !== 64'd3 || alu_input2 !== ONES)
                $display("FAIL mul_hold[T+%0d]: got %b %h %h want 10 3 ffffffffffffffff", c, alu_signal, alu_input1, alu_input2);
            else passed++;
            @(posedge clk);
        end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1) $display("FAIL mul_valid_T+5: got %b want 1", rsp_valid); else passed++;
        checks++; if (rsp_data !== 64'hFFFF_FFFF_FFFF_FFFD) $display("FAIL mul_data: got %h want fffffffffffffffd", rsp_data); else passed++;
        checks++; if (rsp_id !== 1'b1) $display("FAIL mul_id: got %b want 1", rsp_id); else passed++;
        consume();
    endtask

    task automatic test_backpressure();
        int lat;
        rsp_ready = 1'b0;
        do_req(1'b0, OP_SUB, 64'd0, 64'd1);
        req0_op = OP_ADD; req0_a = 64'd1;  req0_b = 64'd2;
        req1_op = OP_ADD; req1_a = 64'd10; req1_b = 64'd20;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        @(negedge clk);
        checks++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL exec_ready: got %b want 00", {req0_ready, req1_ready}); else passed++;
        @(posedge clk);
        #1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== ONES || {req0_ready, req1_ready} !== 2'b00)
                $display("FAIL bp_hold[%0d]: got valid=%b data=%h ready=%b want 1 ffffffffffffffff 00", c, rsp_valid, rsp_data, {req0_ready, req1_ready});
            else passed++;
            @(posedge clk);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++; if ({req0_ready, req1_ready} !== 2'b01) $display("FAIL bp_resume_ready: got %b want 01", {req0_ready, req1_ready}); else passed++;
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_rsp(lat);
        checks++; if (lat != 2) $display("FAIL bp_next_latency: got %0d want 2", lat); else passed++;
        checks++; if (rsp_id !== 1'b1 || rsp_data !== 64'd30) $display("FAIL bp_next_rsp: got id=%b data=%0d want 1 30", rsp_id, rsp_data); else passed++;
        consume();
    endtask

    task automatic test_div();
        int lat;
        int exp_lat;
        logic exp_divz;
`ifdef ALU_ARB_DIVZ_EN
        exp_lat = 1;
        exp_divz = 1'b1;
`else
        exp_lat = 5;
        exp_divz = 1'b0;
`endif
        do_req(1'b0, OP_DIV, 64'd100, 64'd0);
        wait_rsp(lat);
        checks++; if (lat != exp_lat) $display("FAIL divz_latency: got %0d want %0d", lat, exp_lat); else passed++;
        checks++; if (rsp_data !== ONES) $display("FAIL divz_data: got %h want ffffffffffffffff", rsp_data); else passed++;
        checks++; if (rsp_divz !== exp_divz) $display("FAIL divz_flag: got %b want %b", rsp_divz, exp_divz); else passed++;
        checks++; if (alu_input1 !== 64'd100 || alu_input2 !== 64'd0 || alu_signal !== OP_DIV) $display("FAIL divz_alu_load: got %b %0d %0d want 11 100 0", alu_signal, alu_input1, alu_input2); else passed++;
        consume();

        do_req(1'b1, OP_DIV, 64'd100, 64'd7);
        wait_rsp(lat);
        checks++; if (lat != 5) $display("FAIL div_latency: got %0d want 5", lat); else passed++;
        checks++; if (rsp_data !== 64'd14) $display("FAIL div_data: got %0d want 14", rsp_data); else passed++;
        checks++; if (rsp_divz !== 1'b0) $display("FAIL div_flag: got %b want 0", rsp_divz); else passed++;
        consume();
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_op = OP_ADD; req1_op = OP_ADD;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        rsp_ready = 1'b1;
        test_reset();
        test_tie();
        test_mul_latency();
        test_backpressure();
        test_div();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, %0d/%0d passed", passed, checks);
        $fatal(1);
    end

endmodule
